// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver/transmitter state encoding and parity modes.
// The planned uart_tx_cfg uses the same encodings.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  // ones_odd is the XOR of the payload bits and the received parity bit.
  function automatic logic parity_fail(input int mode, input logic ones_odd);
    case (mode)
      PAR_EVEN: return ones_odd;
      PAR_ODD:  return ~ones_odd;
      default:  return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous bit.
// Both flops reset to RESET_VAL so the output is defined from reset onwards.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: DATA_BITS payload, optional even/odd parity,
// 1 or 2 stop bits, sampling at bit centres of an OVERSAMPLE-times tick.
module uart_rx_cfg
  import uart_pkg::*;
#(
  parameter int DATA_BITS   = 8,
  parameter int PARITY_MODE = 0,
  parameter int STOP_BITS   = 1,
  parameter int OVERSAMPLE  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tick,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_done,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int TICK_W = $clog2(OVERSAMPLE);
  localparam logic [TICK_W-1:0] MID_TICK  = TICK_W'(OVERSAMPLE / 2 - 1);
  localparam logic [TICK_W-1:0] LAST_TICK = TICK_W'(OVERSAMPLE - 1);
  localparam logic [2:0] LAST_DATA = 3'(DATA_BITS - 1);
  localparam logic [2:0] LAST_STOP = 3'(STOP_BITS - 1);

  if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_bad_data_bits
    $error("uart_rx_cfg: DATA_BITS must be 5..8");
  end
  if (PARITY_MODE < PAR_NONE || PARITY_MODE > PAR_ODD) begin : g_bad_parity
    $error("uart_rx_cfg: PARITY_MODE must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
    $error("uart_rx_cfg: STOP_BITS must be 1 or 2");
  end
  if (OVERSAMPLE < 4 || (OVERSAMPLE % 2) != 0) begin : g_bad_oversample
    $error("uart_rx_cfg: OVERSAMPLE must be even and at least 4");
  end

  logic rx_s;
  logic rx_d_q;
  logic start_edge;
  logic sample_d;

  uart_state_e          state_q;
  logic [TICK_W-1:0]    tick_cnt_q;
  logic [2:0]           bit_cnt_q;
  logic [DATA_BITS-1:0] shift_q;
  logic                 perr_q;
  logic                 ferr_q;
  logic [DATA_BITS-1:0] rx_data_q;
  logic                 rx_done_q;
  logic                 parity_err_q;
  logic                 frame_err_q;
  logic                 busy_q;

  sync_2ff #(
    .RESET_VAL(1'b1)
  ) u_rx_sync (
    .clk  (clk),
    .rst_n(rst),
    .d_i  (rx),
    .q_o  (rx_s)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_d_q <= 1'b1;
    end else begin
      rx_d_q <= rx_s;
    end
  end

  // Requiring rx_d high keeps a stuck-low line (break) from retriggering.
  assign start_edge = rx_d_q & ~rx_s;

  always_comb begin
    sample_d = 1'b0;
    if (tick) begin
      case (state_q)
        ST_START:                   sample_d = (tick_cnt_q == MID_TICK);
        ST_DATA, ST_PARITY, ST_STOP: sample_d = (tick_cnt_q == LAST_TICK);
        default:                    sample_d = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      tick_cnt_q   <= '0;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      perr_q       <= 1'b0;
      ferr_q       <= 1'b0;
      rx_data_q    <= '0;
      rx_done_q    <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      rx_done_q <= 1'b0;

      // After the half-bit start sample the counter restarts, so every later
      // sample lands a whole bit period on, at the bit centre.
      if (tick && state_q != ST_IDLE) begin
        tick_cnt_q <= sample_d ? '0 : tick_cnt_q + 1'b1;
      end

      case (state_q)
        ST_IDLE: begin
          if (start_edge) begin
            state_q    <= ST_START;
            busy_q     <= 1'b1;
            tick_cnt_q <= '0;
            bit_cnt_q  <= '0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
          end
        end

        ST_START: begin
          if (sample_d) begin
            if (rx_s) begin
              state_q <= ST_IDLE;
              busy_q  <= 1'b0;
            end else begin
              state_q <= ST_DATA;
            end
          end
        end

        ST_DATA: begin
          if (sample_d) begin
            shift_q <= {rx_s, shift_q[DATA_BITS-1:1]};
            if (bit_cnt_q == LAST_DATA) begin
              bit_cnt_q <= '0;
              state_q   <= (PARITY_MODE == PAR_NONE) ? ST_STOP : ST_PARITY;
            end else begin
              bit_cnt_q <= bit_cnt_q + 3'd1;
            end
          end
        end

        ST_PARITY: begin
          if (sample_d) begin
            perr_q  <= parity_fail(PARITY_MODE, (^shift_q) ^ rx_s);
            state_q <= ST_STOP;
          end
        end

        ST_STOP: begin
          if (sample_d) begin
            if (bit_cnt_q == LAST_STOP) begin
              // Leave at the centre of the last stop bit to allow back-to-back frames.
              rx_data_q    <= shift_q;
              parity_err_q <= perr_q;
              frame_err_q  <= ferr_q | ~rx_s;
              rx_done_q    <= 1'b1;
              bit_cnt_q    <= '0;
              state_q      <= ST_IDLE;
              busy_q       <= 1'b0;
            end else begin
              ferr_q    <= ferr_q | ~rx_s;
              bit_cnt_q <= bit_cnt_q + 3'd1;
            end
          end
        end

        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign rx_data    = rx_data_q;
  assign rx_done    = rx_done_q;
  assign parity_err = parity_err_q;
  assign frame_err  = frame_err_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Directed bench for uart_rx_cfg: 8N1, 8E1 and 7O2 instances share clk, tick and reset.
// Tick runs every 4 clk, so one bit period (16 ticks) is 64 clk = 640 time units.
module tb_uart_rx_cfg;

  localparam int BIT_T = 640;

  logic       clk;
  logic       rst;
  logic       tick;
  logic [2:0] rx_v;

  logic [7:0] rx_data0, rx_data1;
  logic [6:0] rx_data2;
  logic       rx_done0, rx_done1, rx_done2;
  logic       perr0, perr1, perr2;
  logic       ferr0, ferr1, ferr2;
  logic       busy0, busy1, busy2;

  int n_cmp = 0;
  int n_bad = 0;

  uart_rx_cfg #(.DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(1), .OVERSAMPLE(16)) u_8n1 (
    .clk(clk), .rst(rst), .tick(tick), .rx(rx_v[0]),
    .rx_data(rx_data0), .rx_done(rx_done0), .parity_err(perr0),
    .frame_err(ferr0), .busy(busy0)
  );

  uart_rx_cfg #(.DATA_BITS(8), .PARITY_MODE(1), .STOP_BITS(1), .OVERSAMPLE(16)) u_8e1 (
    .clk(clk), .rst(rst), .tick(tick), .rx(rx_v[1]),
    .rx_data(rx_data1), .rx_done(rx_done1), .parity_err(perr1),
    .frame_err(ferr1), .busy(busy1)
  );

  uart_rx_cfg #(.DATA_BITS(7), .PARITY_MODE(2), .STOP_BITS(2), .OVERSAMPLE(16)) u_7o2 (
    .clk(clk), .rst(rst), .tick(tick), .rx(rx_v[2]),
    .rx_data(rx_data2), .rx_done(rx_done2), .parity_err(perr2),
    .frame_err(ferr2), .busy(busy2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    int tdiv;
    tdiv = 0;
    tick = 1'b0;
    forever begin
      @(negedge clk);
      tdiv = (tdiv + 1) % 4;
      tick = (tdiv == 0);
    end
  end

  // Completion capture, sampled on the falling edge.
  int         done0 = 0, done1 = 0, done2 = 0;
  logic [7:0] cap_data0, cap_data1;
  logic       cap_pe0, cap_fe0, cap_pe1, cap_fe1;
  logic [6:0] hist2 [0:15];
  logic       err2_acc = 1'b0;

  always @(negedge clk) begin
    if (rx_done0) begin
      done0     <= done0 + 1;
      cap_data0 <= rx_data0;
      cap_pe0   <= perr0;
      cap_fe0   <= ferr0;
    end
    if (rx_done1) begin
      done1     <= done1 + 1;
      cap_data1 <= rx_data1;
      cap_pe1   <= perr1;
      cap_fe1   <= ferr1;
    end
    if (rx_done2) begin
      if (done2 < 16) hist2[done2] <= rx_data2;
      done2    <= done2 + 1;
      err2_acc <= err2_acc | perr2 | ferr2;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // bits[0] goes on the wire first (start bit), one bit period each.
  task automatic send_frame(input int ch, input logic [15:0] bits, input int n);
    $display("tx ch%0d: %0d bits, pattern 0x%04h", ch, n, bits);
    for (int i = 0; i < n; i++) begin
      rx_v[ch] = bits[i];
      #(BIT_T);
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "timeout");
  end

  initial begin
    int base0, base1, base2;

    rx_v = 3'b111;
    rst  = 1'b0;
    #52;
    check("reset_rx_data", 32'(rx_data0), 32'h0);
    check("reset_rx_done", 32'(rx_done0), 32'h0);
    check("reset_parity_err", 32'(perr0), 32'h0);
    check("reset_frame_err", 32'(ferr0), 32'h0);
    check("reset_busy", 32'(busy0), 32'h0);
    #10 rst = 1'b1;
    #(2 * BIT_T);

    // 8N1 basic
    base0 = done0;
    send_frame(0, {6'b0, 1'b1, 8'h55, 1'b0}, 10);
    #(BIT_T);
    check("8n1_done_count", 32'(done0 - base0), 32'd1);
    check("8n1_data", 32'(cap_data0), 32'h55);
    check("8n1_parity_err", 32'(cap_pe0), 32'h0);
    check("8n1_frame_err", 32'(cap_fe0), 32'h0);
    check("8n1_busy_after", 32'(busy0), 32'h0);
    $display("8n1 frame: rx_data=0x%02h", rx_data0);

    // 8E1 parity good then bad
    base1 = done1;
    send_frame(1, {5'b0, 1'b1, 1'b0, 8'hA3, 1'b0}, 11);
    #(BIT_T);
    check("8e1_good_count", 32'(done1 - base1), 32'd1);
    check("8e1_good_data", 32'(cap_data1), 32'hA3);
    check("8e1_good_perr", 32'(cap_pe1), 32'h0);
    send_frame(1, {5'b0, 1'b1, 1'b1, 8'hA3, 1'b0}, 11);
    #(BIT_T);
    check("8e1_bad_count", 32'(done1 - base1), 32'd2);
    check("8e1_bad_data", 32'(cap_data1), 32'hA3);
    check("8e1_bad_perr", 32'(cap_pe1), 32'h1);
    check("8e1_bad_ferr", 32'(cap_fe1), 32'h0);
    $display("8e1 frames: rx_data=0x%02h parity_err=%0b", rx_data1, perr1);

    // Framing error followed by a break held low
    base0 = done0;
    send_frame(0, {6'b0, 1'b0, 8'h3C, 1'b0}, 10);
    #(3 * BIT_T);
    check("break_done_count", 32'(done0 - base0), 32'd1);
    check("break_data", 32'(cap_data0), 32'h3C);
    check("break_frame_err", 32'(cap_fe0), 32'h1);
    check("break_busy_low", 32'(busy0), 32'h0);
    rx_v[0] = 1'b1;
    #(BIT_T);
    check("break_no_second_done", 32'(done0 - base0), 32'd1);
    send_frame(0, {6'b0, 1'b1, 8'h55, 1'b0}, 10);
    #(BIT_T);
    check("after_break_count", 32'(done0 - base0), 32'd2);
    check("after_break_ferr", 32'(ferr0), 32'h0);
    $display("break sequence: frame_err=%0b rx_data=0x%02h", ferr0, rx_data0);

    // False start: 5-tick low glitch
    base0 = done0;
    rx_v[0] = 1'b0;
    #200;
    rx_v[0] = 1'b1;
    check("false_start_busy_high", 32'(busy0), 32'h1);
    #(BIT_T);
    check("false_start_busy_low", 32'(busy0), 32'h0);
    check("false_start_no_done", 32'(done0 - base0), 32'd0);
    $display("false start: busy=%0b", busy0);

    // Reset during data bit 3, then a clean frame
    base0 = done0;
    rx_v[0] = 1'b0; #(BIT_T);
    rx_v[0] = 1'b0; #(BIT_T);
    rx_v[0] = 1'b1; #(BIT_T);
    rx_v[0] = 1'b0; #(BIT_T);
    rx_v[0] = 1'b1; #(BIT_T / 2);
    rst = 1'b0;
    rx_v[0] = 1'b1;
    #1;
    check("midrst_rx_data", 32'(rx_data0), 32'h0);
    check("midrst_busy", 32'(busy0), 32'h0);
    check("midrst_frame_err", 32'(ferr0), 32'h0);
    check("midrst_rx_done", 32'(rx_done0), 32'h0);
    #9;
    #40 rst = 1'b1;
    #(2 * BIT_T);
    check("midrst_no_done", 32'(done0 - base0), 32'd0);
    send_frame(0, {6'b0, 1'b1, 8'hC1, 1'b0}, 10);
    #(BIT_T);
    check("midrst_after_count", 32'(done0 - base0), 32'd1);
    check("midrst_after_data", 32'(cap_data0), 32'hC1);
    $display("reset recovery: rx_data=0x%02h", rx_data0);

    // 7O2 back-to-back, no idle gap
    base2 = done2;
    send_frame(2, {5'b0, 2'b11, 1'b1, 7'h00, 1'b0}, 11);
    send_frame(2, {5'b0, 2'b11, 1'b0, 7'h7F, 1'b0}, 11);
    #(BIT_T);
    check("b2b_count", 32'(done2 - base2), 32'd2);
    check("b2b_first", 32'(hist2[base2]), 32'h00);
    check("b2b_second", 32'(hist2[base2+1]), 32'h7F);
    check("b2b_errors", 32'(err2_acc), 32'h0);
    check("b2b_final_data", 32'(rx_data2), 32'h7F);
    $display("7o2 back-to-back: last rx_data=0x%02h", rx_data2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
